// File: rtl/serial_tx_pkg.sv
// Shared state encoding and line levels for the serial frame transmitter.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period timer: free-runs while enabled and flags the last clock of each
// serial bit. With BIT_CYCLES=1 the tick is permanently high.
module bit_tick_gen #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_r;

  assign tick = (cnt_r == TERM);

  // cycle counter, held at zero whenever no frame is in progress
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (!en) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/serial_frame_tx_moore.sv
// Moore serial frame transmitter: start bit, LSB-first data, optional parity,
// stop bit. Every output is decoded from registered state only.
module serial_frame_tx_moore
  import serial_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             x_out,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_t        state_r, state_next_s;
  logic [WIDTH-1:0] shreg_r, shreg_next_s;
  logic [BW-1:0]    bit_cnt_r, bit_cnt_next_s;
  logic             parity_r, parity_next_s;
  logic             tick_s;
  logic             accept_s;

  function automatic logic calc_parity(input logic [WIDTH-1:0] word);
    logic p;
    p = ^word;
    if (PARITY_ODD != 0) begin
      calc_parity = ~p;
    end else begin
      calc_parity = p;
    end
  endfunction

  bit_tick_gen #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .en   (busy),
    .tick (tick_s)
  );

  // state, shift register, bit counter and parity registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      shreg_r   <= '0;
      bit_cnt_r <= '0;
      parity_r  <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      shreg_r   <= shreg_next_s;
      bit_cnt_r <= bit_cnt_next_s;
      parity_r  <= parity_next_s;
    end
  end

  // handshake flags; ready also opens in the last STOP clock for gapless frames
  always_comb begin
    busy     = (state_r != IDLE);
    done     = (state_r == STOP) && tick_s;
    ready    = (state_r == IDLE) || done;
    accept_s = load && ready;
  end

  // next-state logic; state advances only on bit ticks, except the IDLE accept
  always_comb begin
    state_next_s   = state_r;
    shreg_next_s   = shreg_r;
    bit_cnt_next_s = bit_cnt_r;
    parity_next_s  = parity_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s  = START;
          shreg_next_s  = data_in;
          parity_next_s = calc_parity(data_in);
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          state_next_s   = DATA;
          bit_cnt_next_s = '0;
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          shreg_next_s = shreg_r >> 1;
          if (bit_cnt_r == LAST_BIT) begin
            bit_cnt_next_s = '0;
            if (PARITY_EN != 0) begin
              state_next_s = PARITY;
            end else begin
              state_next_s = STOP;
            end
          end else begin
            bit_cnt_next_s = bit_cnt_r + BW'(1);
          end
        end else begin
          state_next_s = DATA;
        end
      end
      PARITY: begin
        if (tick_s) begin
          state_next_s = STOP;
        end else begin
          state_next_s = PARITY;
        end
      end
      STOP: begin
        if (tick_s && accept_s) begin
          state_next_s  = START;
          shreg_next_s  = data_in;
          parity_next_s = calc_parity(data_in);
        end else if (tick_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = STOP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // serial line level decoded from the current state
  always_comb begin
    x_out = LINE_IDLE;
    case (state_r)
      IDLE:    x_out = LINE_IDLE;
      START:   x_out = START_LVL;
      DATA:    x_out = shreg_r[0];
      PARITY:  x_out = parity_r;
      STOP:    x_out = STOP_LVL;
      default: x_out = LINE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx_moore.sv
// Bench for serial_frame_tx_moore: four parameterisations side by side, each
// frame checked cycle by cycle against a bit list built from the frame rules.
module tb_serial_frame_tx_moore;

  typedef bit bitq_t[$];

  localparam int P_EN  [4] = '{1, 1, 0, 1};
  localparam int P_ODD [4] = '{0, 1, 0, 0};
  localparam int P_BC  [4] = '{1, 1, 1, 4};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in_s [4];
  logic       load_s    [4];
  logic       ready_s   [4];
  logic       x_s       [4];
  logic       busy_s    [4];
  logic       done_s    [4];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  serial_frame_tx_moore #(.WIDTH(8), .BIT_CYCLES(1), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clock(clock), .reset(reset), .data_in(data_in_s[0]), .load(load_s[0]),
    .ready(ready_s[0]), .x_out(x_s[0]), .busy(busy_s[0]), .done(done_s[0]));
  serial_frame_tx_moore #(.WIDTH(8), .BIT_CYCLES(1), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clock(clock), .reset(reset), .data_in(data_in_s[1]), .load(load_s[1]),
    .ready(ready_s[1]), .x_out(x_s[1]), .busy(busy_s[1]), .done(done_s[1]));
  serial_frame_tx_moore #(.WIDTH(8), .BIT_CYCLES(1), .PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
    .clock(clock), .reset(reset), .data_in(data_in_s[2]), .load(load_s[2]),
    .ready(ready_s[2]), .x_out(x_s[2]), .busy(busy_s[2]), .done(done_s[2]));
  serial_frame_tx_moore #(.WIDTH(8), .BIT_CYCLES(4), .PARITY_EN(1), .PARITY_ODD(0)) u_slow (
    .clock(clock), .reset(reset), .data_in(data_in_s[3]), .load(load_s[3]),
    .ready(ready_s[3]), .x_out(x_s[3]), .busy(busy_s[3]), .done(done_s[3]));

  // expected line, one entry per clock: start, data LSB first, parity, stop
  function automatic bitq_t frame_bits(input logic [7:0] w, input int pen, input int podd,
                                       input int bc);
    bitq_t bits;
    bitq_t line;
    int ones;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(w[i]);
      ones += int'(w[i]);
    end
    if (pen != 0) begin
      bits.push_back(podd != 0 ? ((ones % 2) == 0) : ((ones % 2) == 1));
    end
    bits.push_back(1'b1);
    foreach (bits[i]) repeat (bc) line.push_back(bits[i]);
    return line;
  endfunction

  task automatic test_reset();
    logic [3:0] got;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      load_s[c]    = 1'b0;
      data_in_s[c] = 8'($urandom);
    end
    repeat (2) @(negedge clock);
    for (int c = 0; c < 4; c++) begin
      got = {x_s[c], busy_s[c], done_s[c], ready_s[c]};
      total++;
      if (got !== 4'b1001) begin
        bad++;
        $display("FAIL reset_hold cfg=%0d got=%b exp=1001", c, got);
      end
    end
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      for (int c = 0; c < 4; c++) begin
        data_in_s[c] = 8'($urandom);
        got = {x_s[c], busy_s[c], done_s[c], ready_s[c]};
        total++;
        if (got !== 4'b1001) begin
          bad++;
          $display("FAIL reset_idle cfg=%0d cyc=%0d got=%b exp=1001", c, k, got);
        end
      end
    end
  endtask

  // first frame uses the given word, then n random words with random gaps
  task automatic test_frames(input int cfg, input logic [7:0] first, input int n);
    bitq_t      q;
    logic [7:0] w;
    logic [3:0] got, exp;
    int         len;
    for (int f = 0; f <= n; f++) begin
      w   = (f == 0) ? first : 8'($urandom);
      q   = frame_bits(w, P_EN[cfg], P_ODD[cfg], P_BC[cfg]);
      len = q.size();
      total++;
      if (ready_s[cfg] !== 1'b1) begin
        bad++;
        $display("FAIL ready_before_load cfg=%0d got=%b exp=1", cfg, ready_s[cfg]);
      end
      data_in_s[cfg] = w;
      load_s[cfg]    = 1'b1;
      for (int i = 1; i <= len; i++) begin
        @(negedge clock);
        load_s[cfg]    = 1'b0;
        data_in_s[cfg] = 8'($urandom);
        got = {x_s[cfg], busy_s[cfg], done_s[cfg], ready_s[cfg]};
        exp = {q[i-1], 1'b1, (i == len), (i == len)};
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL frame cfg=%0d word=%h cyc=%0d got=%b exp=%b", cfg, w, i, got, exp);
        end
      end
      repeat ($urandom_range(1, 3)) begin
        @(negedge clock);
        got = {x_s[cfg], busy_s[cfg], done_s[cfg], ready_s[cfg]};
        total++;
        if (got !== 4'b1001) begin
          bad++;
          $display("FAIL after_frame cfg=%0d word=%h got=%b exp=1001", cfg, w, got);
        end
      end
    end
  endtask

  // second word offered exactly in the done cycle; a mid-frame offer is ignored
  task automatic test_back_to_back();
    bitq_t      q1, q2, q;
    logic [7:0] w1;
    logic [3:0] got, exp;
    int         len1, tot;
    w1   = 8'($urandom);
    q1   = frame_bits(w1, 1, 0, 1);
    q2   = frame_bits(8'h55, 1, 0, 1);
    q    = {q1, q2};
    len1 = q1.size();
    tot  = q.size();
    data_in_s[0] = w1;
    load_s[0]    = 1'b1;
    for (int i = 1; i <= tot; i++) begin
      @(negedge clock);
      got = {x_s[0], busy_s[0], done_s[0], ready_s[0]};
      exp = {q[i-1], 1'b1, (i == len1 || i == tot), (i == len1 || i == tot)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL back_to_back word=%h cyc=%0d got=%b exp=%b", w1, i, got, exp);
      end
      if (i >= 3 && i <= 5) begin
        load_s[0] = 1'b1;  data_in_s[0] = 8'hFF;
      end else if (i == len1) begin
        load_s[0] = 1'b1;  data_in_s[0] = 8'h55;
      end else begin
        load_s[0] = 1'b0;  data_in_s[0] = 8'($urandom);
      end
    end
    @(negedge clock);
    got = {x_s[0], busy_s[0], done_s[0], ready_s[0]};
    total++;
    if (got !== 4'b1001) begin
      bad++;
      $display("FAIL back_to_back_idle got=%b exp=1001", got);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] got;
    data_in_s[0] = 8'hA5;
    load_s[0]    = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      load_s[0] = 1'b0;
    end
    total++;
    if (x_s[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_frame_bit3 got=%b exp=0", x_s[0]);
    end
    #2 reset = 1'b0;
    #1;
    got = {x_s[0], busy_s[0], done_s[0], ready_s[0]};
    total++;
    if (got !== 4'b1001) begin
      bad++;
      $display("FAIL async_abort got=%b exp=1001", got);
    end
    repeat (3) begin
      @(negedge clock);
      got = {x_s[0], busy_s[0], done_s[0], ready_s[0]};
      total++;
      if (got !== 4'b1001) begin
        bad++;
        $display("FAIL reset_held got=%b exp=1001", got);
      end
    end
    reset = 1'b1;
    test_frames(0, 8'h5A, 0);
  endtask

  initial begin
    test_reset();
    test_frames(0, 8'hA5, 6);
    test_frames(1, 8'h01, 6);
    test_frames(2, 8'hFF, 6);
    test_frames(3, 8'h3C, 3);
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx_moore.md
Name: serial_frame_tx_moore

Overview:
Moore-style serial frame transmitter. It is the sending end of the single-bit serial input stream that our Moore sequence detectors consume.
- Accepts a parallel word through a valid/ready handshake.
- Emits the word on one serial line as: start bit, data bits LSB first, optional parity bit, stop bit.
- All outputs are decoded from registered state only (Moore), so the line is glitch-free for downstream detectors clocked on the same clock.

Parameters:
WIDTH, 8, number of data bits per frame (>=2)
BIT_CYCLES, 1, clock cycles each serial bit is held (>=1)
PARITY_EN, 1, 1 = insert parity bit after data; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity; 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clock  input  1  single clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
data_in  input  WIDTH  word to transmit; sampled only on the accept edge
load  input  1  request to send data_in
ready  output  1  block can accept a word this cycle
x_out  output  1  serial line; idle level 1
busy  output  1  frame in progress (any state except IDLE)
done  output  1  high for exactly the final clock of the STOP bit

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP.
- State register, shift register and counters are all cleared asynchronously when reset=0.
- Outputs while reset is asserted: x_out=1, busy=0, ready=1, done=0, state=IDLE.
- Accept: a word is accepted on a rising edge where load=1 and ready=1.
  - data_in is captured into the shift register.
  - Parity is computed from the captured word: even = ^data_in, odd = ~^data_in.
  - State goes to START.
- Output decode per state:
  - IDLE: x_out=1.
  - START: x_out=0.
  - DATA: x_out=shreg[0].
  - PARITY: x_out=the stored parity bit.
  - STOP: x_out=1.
- Latency: x_out falls on the first clock after the accept edge. No combinational path from load or data_in to any output.
- Bit timing: each state/bit is held for exactly BIT_CYCLES clocks. A cycle counter (0..BIT_CYCLES-1) produces a tick on its terminal count.
- Transitions, taken only on a tick:
  - START -> DATA, with bit_cnt=0.
  - DATA: shreg shifts right by one and bit_cnt increments. After bit WIDTH-1, go to PARITY if PARITY_EN, otherwise to STOP.
  - PARITY -> STOP.
  - STOP -> IDLE, or -> START if a word is accepted on that edge.
- Frame length is (2 + WIDTH + PARITY_EN) * BIT_CYCLES clocks.
- ready is 1 in IDLE, and in the final clock of STOP (tick asserted). This allows back-to-back frames with no idle gap. ready is 0 otherwise.
- load while ready=0 is ignored, and data_in is not sampled. The requester must hold load until it sees ready.
- done = (state==STOP) && tick. done and ready are both high in that cycle.
- Reset mid-frame: the frame is aborted, x_out returns to 1 immediately (asynchronously), and no done is produced. The first accept after reset release starts a clean frame.
- bit_cnt width is $clog2(WIDTH). Cycle counter width is max(1, $clog2(BIT_CYCLES)). Both wrap to 0 on the terminal tick.
- With BIT_CYCLES=1 the tick is constantly 1.

Decomposition:
- Package serial_tx_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam LINE_IDLE=1'b1, START_LVL=1'b0, STOP_LVL=1'b1.
- Sub-module bit_tick_gen (parameter BIT_CYCLES; ports clock, reset, en, tick):
  - counts while en=1 (busy);
  - clears when en=0;
  - tick is high on the terminal count.
- FSM, shift register and output decode stay in the top module.

Test Plan:
- Reset: hold reset=0 for 2 clocks -> x_out=1, busy=0, ready=1, done=0. Release, no load -> outputs unchanged for 20 clocks.
- Basic frame (WIDTH=8, BIT_CYCLES=1, even parity): load 8'hA5 -> x_out over 11 clocks = 0,1,0,1,0,0,1,0,1,0,1. done high on clock 11 only; busy high for all 11 clocks.
- Odd parity / no parity:
  - PARITY_ODD=1 with 8'h01 -> parity bit 0 (frame 0,1,0,0,0,0,0,0,0,0,1).
  - PARITY_EN=0 with 8'hFF -> 10-bit frame 0,1,1,1,1,1,1,1,1,1.
- Bit stretching: BIT_CYCLES=4, load 8'h3C -> each bit held exactly 4 clocks; total 44 clocks; done for 1 clock.
- Back-to-back: assert load with 8'h55 during the done cycle of the previous frame -> the next clock x_out=0 (new start bit), no idle cycle. load asserted mid-frame with 8'hFF is ignored, and the current frame is unchanged.
- Reset mid-frame: pull reset low during data bit 3 of 8'hA5 -> x_out=1 immediately (before the next edge), busy=0, no done. After release, load 8'h5A -> a complete correct frame.
